// File: rtl/port_tx_pkg.sv
// port_tx_buf shared types and constants.
// Word tags, data width, default buffer geometry, read FSM states.
package port_tx_pkg;

  localparam int DATA_W = 134;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 2;
  localparam int LW_DEF = 8;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_e;

endpackage

// File: rtl/tx_desc_fifo.sv
// Packet-length descriptor FIFO, 2^DW deep, LW wide, show-ahead read.
// Ports: push/push_data, pop/pop_data, full, empty.
module tx_desc_fifo #(
  parameter int LW = 8,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [LW-1:0] push_data,
  input  logic          pop,
  output logic [LW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << DW;

  logic [LW-1:0] mem [DEPTH];
  logic [DW-1:0] wr_q, wr_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [DW:0]   cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (cnt_q == DEPTH[DW:0]);
  assign empty    = (cnt_q == '0);
  assign pop_data = mem[rd_q];

  // full is judged on the registered count, before any same-cycle pop
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/port_tx_buf.sv
// Per-port egress buffer: stores whole packets, commits/discards on in_valid_wr,
// drains committed packets to tx_* under tx_ready; reports out_usedw and counters.
module port_tx_buf
  import port_tx_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_wr,
  input  logic              in_valid,
  input  logic              in_valid_wr,
  output logic [AW-1:0]     out_usedw,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_wr,
  input  logic              tx_ready,
  output logic [31:0]       tx_pkt_cnt,
  output logic [31:0]       drop_cnt
);

  logic [DATA_W-1:0] mem [1 << AW];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     usedw_q, usedw_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]       tx_pkt_cnt_q, tx_pkt_cnt_d;
  logic [LW-1:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_data_wr_q, tx_data_wr_d;
  rd_state_e         state_q, state_d;

  logic [AW-1:0] used;
  logic [AW-1:0] wr_ptr_nx;
  logic [LW-1:0] len;
  logic          wr_acc;
  logic          ovf_hit;
  logic          commit_ok;
  logic          desc_full;
  logic          desc_empty;
  logic          desc_pop;
  logic [LW-1:0] desc_len;
  logic          rd_issue;

  // one slot stays free so the fill level fits in AW bits
  assign used      = wr_ptr_q - rd_ptr_q;
  assign wr_acc    = in_data_wr && (used != '1);
  assign ovf_hit   = in_data_wr && (used == '1);
  assign wr_ptr_nx = wr_ptr_q + AW'(wr_acc);
  assign len       = LW'(wr_ptr_nx - commit_ptr_q);
  assign commit_ok = in_valid_wr && in_valid && !ovf_q && !ovf_hit
                   && !desc_full && (len != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_nx;
    commit_ptr_d = commit_ptr_q;
    ovf_d        = ovf_q | ovf_hit;
    drop_cnt_d   = drop_cnt_q;
    if (in_valid_wr) begin
      ovf_d = 1'b0;
      if (commit_ok) begin
        commit_ptr_d = wr_ptr_nx;
      end else begin
        wr_ptr_d   = commit_ptr_q;
        drop_cnt_d = drop_cnt_q + 32'd1;
      end
    end
  end

  tx_desc_fifo #(
    .LW (LW),
    .DW (DW)
  ) u_desc (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit_ok),
    .push_data (len),
    .pop       (desc_pop),
    .pop_data  (desc_len),
    .full      (desc_full),
    .empty     (desc_empty)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    rd_ptr_d     = rd_ptr_q;
    tx_pkt_cnt_d = tx_pkt_cnt_q;
    desc_pop     = 1'b0;
    rd_issue     = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (!desc_empty) begin
          desc_pop    = 1'b1;
          remaining_d = desc_len;
          state_d     = RD_SEND;
        end
      end
      RD_SEND: begin
        if (tx_ready) begin
          rd_issue    = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LW'(1)) begin
            tx_pkt_cnt_d = tx_pkt_cnt_q + 32'd1;
            state_d      = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign usedw_d      = wr_ptr_d - rd_ptr_d;
  assign tx_data_wr_d = rd_issue;
  assign tx_data_d    = rd_issue ? mem[rd_ptr_q] : tx_data_q;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      usedw_q      <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
      tx_pkt_cnt_q <= '0;
      remaining_q  <= '0;
      tx_data_q    <= '0;
      tx_data_wr_q <= 1'b0;
      state_q      <= RD_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      usedw_q      <= usedw_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
      tx_pkt_cnt_q <= tx_pkt_cnt_d;
      remaining_q  <= remaining_d;
      tx_data_q    <= tx_data_d;
      tx_data_wr_q <= tx_data_wr_d;
      state_q      <= state_d;
    end
  end

  assign out_usedw  = usedw_q;
  assign tx_data    = tx_data_q;
  assign tx_data_wr = tx_data_wr_q;
  assign tx_pkt_cnt = tx_pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_port_tx_buf.sv
// Self-checking bench for port_tx_buf: packet table, corner sequences,
// randomized traffic against a packet-level queue model.
module tb_port_tx_buf;
  import port_tx_pkg::*;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct {
    int n;
    bit valid;
    bit sep;
    int used_after;
    int drop_inc;
    int peak;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  word_t       in_data;
  logic        in_data_wr;
  logic        in_valid;
  logic        in_valid_wr;
  logic [7:0]  out_usedw;
  word_t       tx_data;
  logic        tx_data_wr;
  logic        tx_ready;
  logic [31:0] tx_pkt_cnt;
  logic [31:0] drop_cnt;

  always #5 clk = ~clk;

  port_tx_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_data_wr  (in_data_wr),
    .in_valid    (in_valid),
    .in_valid_wr (in_valid_wr),
    .out_usedw   (out_usedw),
    .tx_data     (tx_data),
    .tx_data_wr  (tx_data_wr),
    .tx_ready    (tx_ready),
    .tx_pkt_cnt  (tx_pkt_cnt),
    .drop_cnt    (drop_cnt)
  );

  int    cyc = 0;
  word_t exp_q[$];
  word_t rx_q[$];
  int    rx_cyc[$];
  int    bad_pulse = 0;
  int    max_used = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    m_drop = 0;
  int    m_tx = 0;
  int    ptr_model = 0;
  int    commit_cyc = 0;
  int    rdy_mode = 0;
  logic  rdy_edge;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    rdy_edge = tx_ready;
    #2;
    if (rst_n === 1'b1) begin
      if (tx_data_wr === 1'b1) begin
        rx_q.push_back(tx_data);
        rx_cyc.push_back(cyc);
        if (rdy_edge !== 1'b1) bad_pulse++;
      end
      if (int'(out_usedw) > max_used) max_used = int'(out_usedw);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, word_t act, word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  function automatic word_t mkword(int i, int n);
    logic [1:0] tag;
    tag = (i == n - 1 && n > 1) ? TAG_TAIL : (i == 0) ? TAG_HEAD : TAG_MID;
    return {tag, 4'($urandom_range(0, 15)),
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: a packet survives when valid, non-empty, not over capacity
  // (buffer assumed empty at start) and the caller says the queue has room.
  task automatic send_pkt(int n, bit valid, bit sep, bit full_hint);
    word_t pkt[$];
    word_t w;
    bit    keep;
    keep = valid && n > 0 && n <= 255 && !full_hint;
    for (int i = 0; i < n; i++) begin
      w = mkword(i, n);
      in_data = w;
      in_data_wr = 1'b1;
      if (i < 255) pkt.push_back(w);
      if (!sep && i == n - 1) begin
        in_valid_wr = 1'b1;
        in_valid = valid;
        commit_cyc = cyc;
      end
      tick();
      in_data_wr = 1'b0;
      in_valid_wr = 1'b0;
      in_valid = 1'b0;
    end
    if (sep || n == 0) begin
      in_valid_wr = 1'b1;
      in_valid = valid;
      commit_cyc = cyc;
      tick();
      in_valid_wr = 1'b0;
      in_valid = 1'b0;
    end
    if (keep) begin
      foreach (pkt[k]) exp_q.push_back(pkt[k]);
      m_tx++;
      ptr_model = (ptr_model + n) % 256;
    end else begin
      m_drop++;
    end
  endtask

  task automatic wait_drain(string name);
    int b = 0;
    while (rx_q.size() < exp_q.size() && b < 3000) begin
      tick();
      b++;
    end
    if (b >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s drain timeout: got %0d words want %0d",
               name, rx_q.size(), exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic compare_rx(string name);
    int n;
    chk({name, " word count"}, word_t'(rx_q.size()), word_t'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s word %0d", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  vec_t vt[7];

  initial begin
    int base_drop;
    int fill;
    int k;
    int b;

    vt[0] = '{4,   1'b1, 1'b0, 4,   0, 4};
    vt[1] = '{3,   1'b0, 1'b1, 0,   1, 3};
    vt[2] = '{1,   1'b1, 1'b0, 1,   0, 1};
    vt[3] = '{0,   1'b1, 1'b0, 0,   1, 0};
    vt[4] = '{255, 1'b1, 1'b1, 255, 0, 255};
    vt[5] = '{260, 1'b1, 1'b1, 0,   1, 255};
    vt[6] = '{5,   1'b1, 1'b1, 5,   0, 5};

    rst_n = 1'b0;
    in_data = '0;
    in_data_wr = 1'b0;
    in_valid = 1'b0;
    in_valid_wr = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset usedw", word_t'(out_usedw), '0);
    chk("reset tx_data", tx_data, '0);
    chk("reset tx_data_wr", word_t'(tx_data_wr), '0);
    chk("reset tx_pkt_cnt", word_t'(tx_pkt_cnt), '0);
    chk("reset drop_cnt", word_t'(drop_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Packet table: write with tx_ready low, check fill, then drain.
    for (int v = 0; v < 7; v++) begin
      rdy_mode = 0;
      tx_ready = 1'b0;
      max_used = 0;
      base_drop = m_drop;
      send_pkt(vt[v].n, vt[v].valid, vt[v].sep, 1'b0);
      chk($sformatf("vec%0d usedw after commit", v),
          word_t'(out_usedw), word_t'(vt[v].used_after));
      tx_ready = 1'b1;
      wait_drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d peak usedw", v), word_t'(max_used), word_t'(vt[v].peak));
      chk($sformatf("vec%0d drop_cnt", v), word_t'(drop_cnt),
          word_t'(base_drop + vt[v].drop_inc));
      chk($sformatf("vec%0d tx_pkt_cnt", v), word_t'(tx_pkt_cnt), word_t'(m_tx));
      chk($sformatf("vec%0d usedw drained", v), word_t'(out_usedw), '0);
      compare_rx($sformatf("vec%0d", v));
    end

    // First-word latency with ready held high.
    tx_ready = 1'b1;
    send_pkt(4, 1'b1, 1'b0, 1'b0);
    chk("lat usedw", word_t'(out_usedw), 4);
    wait_drain("lat");
    if (rx_cyc.size() == 4) begin
      chk("lat first word", word_t'(rx_cyc[0] - commit_cyc), 3);
      chk("lat back-to-back", word_t'(rx_cyc[3] - rx_cyc[0]), 3);
    end
    compare_rx("lat");

    // Descriptor full: the first packet is popped into SEND right away,
    // so four more fit in the queue and the sixth is dropped.
    tx_ready = 1'b0;
    for (int p = 0; p < 6; p++) send_pkt(2, 1'b1, 1'b0, p == 5);
    chk("dfull drop_cnt", word_t'(drop_cnt), word_t'(m_drop));
    chk("dfull usedw", word_t'(out_usedw), 10);
    tx_ready = 1'b1;
    wait_drain("dfull");
    if (rx_cyc.size() == 10) begin
      for (int p = 0; p < 5; p++) begin
        chk($sformatf("dfull pair %0d", p),
            word_t'(rx_cyc[2*p+1] - rx_cyc[2*p]), 1);
        if (p > 0)
          chk($sformatf("dfull gap %0d", p),
              word_t'(rx_cyc[2*p] - rx_cyc[2*p-1]), 2);
      end
    end
    chk("dfull tx_pkt_cnt", word_t'(tx_pkt_cnt), word_t'(m_tx));
    compare_rx("dfull");

    // Ready toggling every cycle.
    rdy_mode = 1;
    tx_ready = 1'b1;
    bad_pulse = 0;
    send_pkt(6, 1'b1, 1'b0, 1'b0);
    wait_drain("toggle");
    chk("toggle pulses after ready-low", word_t'(bad_pulse), '0);
    compare_rx("toggle");

    // Random traffic and random backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 25; p++) begin
      send_pkt($urandom_range(1, 24), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), 1'b0);
      wait_drain($sformatf("rand%0d", p));
    end
    chk("rand drop_cnt", word_t'(drop_cnt), word_t'(m_drop));
    chk("rand tx_pkt_cnt", word_t'(tx_pkt_cnt), word_t'(m_tx));
    chk("rand usedw", word_t'(out_usedw), '0);
    chk("rand pulses after ready-low", word_t'(bad_pulse), '0);
    compare_rx("rand");

    // Advance pointers to 250, then a 10-word packet crosses 255->0.
    rdy_mode = 0;
    tx_ready = 1'b1;
    fill = ((250 - ptr_model) % 256 + 256) % 256;
    while (fill > 0) begin
      k = (fill > 100) ? 100 : fill;
      send_pkt(k, 1'b1, 1'b0, 1'b0);
      fill -= k;
      wait_drain("prefill");
    end
    compare_rx("prefill");
    send_pkt(10, 1'b1, 1'b0, 1'b0);
    wait_drain("wrap");
    chk("wrap tx_pkt_cnt", word_t'(tx_pkt_cnt), word_t'(m_tx));
    compare_rx("wrap");

    // Reset in the middle of a drain.
    send_pkt(8, 1'b1, 1'b0, 1'b0);
    b = 0;
    while (rx_q.size() < 2 && b < 100) begin
      tick();
      b++;
    end
    chk("mid-drain words seen before reset", word_t'(rx_q.size() >= 2), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst usedw", word_t'(out_usedw), '0);
    chk("midrst tx_data", tx_data, '0);
    chk("midrst tx_data_wr", word_t'(tx_data_wr), '0);
    chk("midrst tx_pkt_cnt", word_t'(tx_pkt_cnt), '0);
    chk("midrst drop_cnt", word_t'(drop_cnt), '0);
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
    m_drop = 0;
    m_tx = 0;
    ptr_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_pkt(2, 1'b1, 1'b0, 1'b0);
    wait_drain("post-reset");
    chk("post-reset tx_pkt_cnt", word_t'(tx_pkt_cnt), 1);
    compare_rx("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
